// File: rtl/programmable_pulse_oscillator_if.sv
// Configuration write channel of the programmable pulse oscillator.
// The master drives a write; the slave reports when a write may be accepted.
interface programmable_pulse_oscillator_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic [CNT_W-1:0] cfg_burst;

  modport master (
    output cfg_valid, cfg_ch, cfg_high, cfg_low, cfg_burst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_high, cfg_low, cfg_burst,
    output cfg_ready
  );
endinterface

// File: rtl/programmable_pulse_oscillator.sv
// Multi-channel programmable pulse oscillator with per-channel burst counting.
// Each channel runs IDLE/HIGH/LOW; pending config is latched into a shadow on every HIGH entry.
module programmable_pulse_oscillator #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HIGH = 19,
  parameter int unsigned DEF_LOW  = 19
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             enable,
  programmable_pulse_oscillator_if.slave cfg,
  output logic [NUM_CH-1:0]             pulse,
  output logic [NUM_CH-1:0]             active,
  output logic [NUM_CH-1:0]             done
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DefHigh = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DefLow  = CNT_W'(DEF_LOW);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q    [NUM_CH];
  state_e           state_d    [NUM_CH];
  logic [CNT_W-1:0] cnt_q      [NUM_CH];
  logic [CNT_W-1:0] cnt_d      [NUM_CH];
  logic [CNT_W-1:0] bcnt_q     [NUM_CH];
  logic [CNT_W-1:0] bcnt_d     [NUM_CH];
  logic [CNT_W-1:0] sh_high_q  [NUM_CH];
  logic [CNT_W-1:0] sh_high_d  [NUM_CH];
  logic [CNT_W-1:0] sh_low_q   [NUM_CH];
  logic [CNT_W-1:0] sh_low_d   [NUM_CH];
  logic [CNT_W-1:0] sh_burst_q [NUM_CH];
  logic [CNT_W-1:0] sh_burst_d [NUM_CH];
  logic [CNT_W-1:0] pd_high_q  [NUM_CH];
  logic [CNT_W-1:0] pd_high_d  [NUM_CH];
  logic [CNT_W-1:0] pd_low_q   [NUM_CH];
  logic [CNT_W-1:0] pd_low_d   [NUM_CH];
  logic [CNT_W-1:0] pd_burst_q [NUM_CH];
  logic [CNT_W-1:0] pd_burst_d [NUM_CH];
  logic [CNT_W-1:0] high_eff   [NUM_CH];
  logic [CNT_W-1:0] low_eff    [NUM_CH];
  logic [CNT_W-1:0] bcnt_inc   [NUM_CH];
  logic [NUM_CH-1:0] armed_q, armed_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              ready_q;
  logic              cfg_accept;

  assign cfg.cfg_ready = ready_q;
  assign cfg_accept    = cfg.cfg_valid & ready_q;
  assign done          = done_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pulse[i]    = (state_q[i] == StHigh);
      active[i]   = (state_q[i] != StIdle);
      // A programmed length of zero behaves as one clock.
      high_eff[i] = (sh_high_q[i] == '0) ? CntOne : sh_high_q[i];
      low_eff[i]  = (sh_low_q[i] == '0) ? CntOne : sh_low_q[i];
      bcnt_inc[i] = (bcnt_q[i] == CntMax) ? bcnt_q[i] : bcnt_q[i] + CntOne;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    sh_high_d  = sh_high_q;
    sh_low_d   = sh_low_q;
    sh_burst_d = sh_burst_q;
    pd_high_d  = pd_high_q;
    pd_low_d   = pd_low_q;
    pd_burst_d = pd_burst_q;
    armed_d    = armed_q;
    done_d     = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      unique case (state_q[i])
        StIdle: begin
          if (!enable[i]) begin
            armed_d[i] = 1'b1;
          end else if (armed_q[i]) begin
            state_d[i]    = StHigh;
            cnt_d[i]      = '0;
            sh_high_d[i]  = pd_high_q[i];
            sh_low_d[i]   = pd_low_q[i];
            sh_burst_d[i] = pd_burst_q[i];
          end
        end
        StHigh: begin
          if (!enable[i]) begin
            state_d[i] = StIdle;
            bcnt_d[i]  = '0;
          end else if (cnt_q[i] == high_eff[i] - CntOne) begin
            state_d[i] = StLow;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        StLow: begin
          if (!enable[i]) begin
            state_d[i] = StIdle;
            bcnt_d[i]  = '0;
          end else if (cnt_q[i] == low_eff[i] - CntOne) begin
            if ((sh_burst_q[i] != '0) && (bcnt_inc[i] >= sh_burst_q[i])) begin
              state_d[i] = StIdle;
              bcnt_d[i]  = '0;
              done_d[i]  = 1'b1;
              armed_d[i] = 1'b0;
            end else begin
              state_d[i]    = StHigh;
              cnt_d[i]      = '0;
              bcnt_d[i]     = bcnt_inc[i];
              sh_high_d[i]  = pd_high_q[i];
              sh_low_d[i]   = pd_low_q[i];
              sh_burst_d[i] = pd_burst_q[i];
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CntOne;
          end
        end
        default: state_d[i] = StIdle;
      endcase

      // Out-of-range channel numbers match no index and are dropped.
      if (cfg_accept && (cfg.cfg_ch == CH_W'(i))) begin
        pd_high_d[i]  = cfg.cfg_high;
        pd_low_d[i]   = cfg.cfg_low;
        pd_burst_d[i] = cfg.cfg_burst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= StIdle;
        cnt_q[i]      <= '0;
        bcnt_q[i]     <= '0;
        sh_high_q[i]  <= DefHigh;
        sh_low_q[i]   <= DefLow;
        sh_burst_q[i] <= '0;
        pd_high_q[i]  <= DefHigh;
        pd_low_q[i]   <= DefLow;
        pd_burst_q[i] <= '0;
      end
      armed_q <= '1;
      done_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      sh_high_q  <= sh_high_d;
      sh_low_q   <= sh_low_d;
      sh_burst_q <= sh_burst_d;
      pd_high_q  <= pd_high_d;
      pd_low_q   <= pd_low_d;
      pd_burst_q <= pd_burst_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      ready_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_programmable_pulse_oscillator.sv
// Bench for programmable_pulse_oscillator: a period-position model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_programmable_pulse_oscillator;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 16;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] pulse, active, done;

  programmable_pulse_oscillator_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

  programmable_pulse_oscillator #(
    .NUM_CH(NCH), .CNT_W(CW), .DEF_HIGH(19), .DEF_LOW(19)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cfg    (cfg_if),
    .pulse  (pulse),
    .active (active),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running channel sits at position pos within a period of h+l clocks.
  bit          m_started = 0;
  bit          m_ready;
  bit          m_run  [NCH];
  bit          m_arm  [NCH];
  bit          m_done [NCH];
  int unsigned m_pos  [NCH];
  int unsigned m_h    [NCH];
  int unsigned m_l    [NCH];
  int unsigned m_n    [NCH];
  int unsigned m_per  [NCH];
  int unsigned m_ph   [NCH];
  int unsigned m_pl   [NCH];
  int unsigned m_pn   [NCH];

  function automatic int unsigned max1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_arm[c] = 1; m_done[c] = 0; m_pos[c] = 0; m_per[c] = 0;
        m_h[c] = 19; m_l[c] = 19; m_n[c] = 0; m_ph[c] = 19; m_pl[c] = 19; m_pn[c] = 0;
      end
      m_ready = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_done[c] = 0;
        if (m_run[c]) begin
          if (!enable[c]) begin
            m_run[c] = 0; m_per[c] = 0;
          end else begin
            m_pos[c]++;
            if (m_pos[c] == m_h[c] + m_l[c]) begin
              if (m_per[c] < 65535) m_per[c]++;
              if (m_n[c] != 0 && m_per[c] >= m_n[c]) begin
                m_run[c] = 0; m_done[c] = 1; m_arm[c] = 0; m_per[c] = 0;
              end else begin
                m_pos[c] = 0;
                m_h[c] = max1(m_ph[c]); m_l[c] = max1(m_pl[c]); m_n[c] = m_pn[c];
              end
            end
          end
        end else if (!enable[c]) begin
          m_arm[c] = 1;
        end else if (m_arm[c]) begin
          m_run[c] = 1; m_pos[c] = 0;
          m_h[c] = max1(m_ph[c]); m_l[c] = max1(m_pl[c]); m_n[c] = m_pn[c];
        end
      end
      if (cfg_if.cfg_valid && m_ready && cfg_if.cfg_ch < NCH) begin
        m_ph[cfg_if.cfg_ch] = cfg_if.cfg_high;
        m_pl[cfg_if.cfg_ch] = cfg_if.cfg_low;
        m_pn[cfg_if.cfg_ch] = cfg_if.cfg_burst;
      end
      m_ready = 1;
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      logic [NCH-1:0] ep, ea, ed;
      for (int c = 0; c < NCH; c++) begin
        ep[c] = m_run[c] && (m_pos[c] < m_h[c]);
        ea[c] = m_run[c];
        ed[c] = m_done[c];
      end
      chk("model_pulse", 32'(pulse), 32'(ep));
      chk("model_active", 32'(active), 32'(ea));
      chk("model_done", 32'(done), 32'(ed));
      chk("model_ready", 32'(cfg_if.cfg_ready), 32'(m_ready));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int h, input int l, input int b);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_high  = 16'(h);
    cfg_if.cfg_low   = 16'(l);
    cfg_if.cfg_burst = 16'(b);
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_high = '0;
    cfg_if.cfg_low = '0;
    cfg_if.cfg_burst = '0;
    cyc(2);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("ready_after_rst", 32'(cfg_if.cfg_ready), 1);

    // Defaults on channel 0: 19 high, 19 low.
    enable[0] = 1'b1;
    cyc(1);  chk("def_rise", 32'(pulse[0]), 1);
    cyc(18); chk("def_high_last", 32'(pulse[0]), 1);
    cyc(1);  chk("def_low_first", 32'(pulse[0]), 0);
    cyc(18); chk("def_low_last", 32'(pulse[0]), 0);
    cyc(1);  chk("def_period_38", 32'(pulse[0]), 1);

    // Reprogram mid-HIGH: current period stays 19/19, next is 4/4.
    cfg_write(0, 4, 4, 0);
    cyc(17); chk("mid_high_keep", 32'(pulse[0]), 1);
    cyc(1);  chk("mid_high_fall", 32'(pulse[0]), 0);
    cyc(18); chk("mid_low_keep", 32'(pulse[0]), 0);
    cyc(1);  chk("new_rise", 32'(pulse[0]), 1);
    cyc(3);  chk("new_high_last", 32'(pulse[0]), 1);
    cyc(1);  chk("new_low_first", 32'(pulse[0]), 0);
    cyc(3);  chk("new_low_last", 32'(pulse[0]), 0);
    cyc(1);  chk("new_period_8", 32'(pulse[0]), 1);

    // Burst of two 3/5 periods on channel 1.
    cfg_write(1, 3, 5, 2);
    enable[1] = 1'b1;
    cyc(1);  chk("burst_rise", 32'(pulse[1]), 1);
    cyc(15); chk("burst_last_low_act", 32'(active[1]), 1);
    chk("burst_last_low_pulse", 32'(pulse[1]), 0);
    cyc(1);  chk("burst_done", 32'(done[1]), 1);
    chk("burst_idle", 32'(active[1]), 0);
    cyc(1);  chk("burst_done_once", 32'(done[1]), 0);
    cyc(5);  chk("burst_disarmed", 32'(active[1]), 0);
    enable[1] = 1'b0;
    cyc(1);
    enable[1] = 1'b1;
    cyc(1);  chk("burst_rearm", 32'(pulse[1]), 1);

    // Zero lengths on channel 3 toggle every clock; a write on a HIGH-entry edge waits.
    cfg_write(3, 0, 0, 0);
    enable[3] = 1'b1;
    cyc(1);  chk("tog_1", 32'(pulse[3]), 1);
    cyc(1);  chk("tog_2", 32'(pulse[3]), 0);
    cyc(1);  chk("tog_3", 32'(pulse[3]), 1);
    cyc(1);  chk("tog_4", 32'(pulse[3]), 0);
    cfg_write(3, 2, 2, 0);
    chk("same_edge_old", 32'(pulse[3]), 1);
    cyc(1);  chk("same_edge_low", 32'(pulse[3]), 0);
    cyc(1);  chk("same_edge_new1", 32'(pulse[3]), 1);
    cyc(1);  chk("same_edge_new2", 32'(pulse[3]), 1);
    cyc(1);  chk("same_edge_newlow", 32'(pulse[3]), 0);

    // Drop enable on channel 2 mid-LOW, then restart with a full HIGH.
    enable[2] = 1'b1;
    cyc(1);  chk("ch2_rise", 32'(pulse[2]), 1);
    cyc(24); chk("ch2_in_low", 32'(pulse[2]), 0);
    enable[2] = 1'b0;
    cyc(1);  chk("ch2_drop_act", 32'(active[2]), 0);
    chk("ch2_drop_done", 32'(done[2]), 0);
    enable[2] = 1'b1;
    cyc(1);  chk("ch2_restart", 32'(pulse[2]), 1);
    cyc(18); chk("ch2_full_high", 32'(pulse[2]), 1);
    cyc(1);  chk("ch2_low_again", 32'(pulse[2]), 0);

    // One-cycle reset with everything running and a write pending.
    enable = '1;
    cyc(3);
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch = 2'd0;
    cfg_if.cfg_high = 16'd7;
    cfg_if.cfg_low = 16'd7;
    cfg_if.cfg_burst = 16'd0;
    cyc(1);
    chk("mid_rst_pulse", 32'(pulse), 0);
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 0);
    rst_n = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cyc(1);  chk("post_rst_rise", 32'(pulse), 32'hF);
    chk("post_rst_ready", 32'(cfg_if.cfg_ready), 1);
    cyc(18); chk("post_rst_high19", 32'(pulse), 32'hF);
    cyc(1);  chk("post_rst_low", 32'(pulse), 32'h0);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
